// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, branch redirect
// and the valid/ready instruction output toward decode.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // environment side: imem, branch unit and decode
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-word reads to a
// synchronous-read imem, buffers {instr, pc} in a 2-entry FIFO and hands
// them downstream over valid/ready. Redirects flush buffered and
// in-flight fetches.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               SIZE     = 23,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  // imem only decodes SIZE word-address bits above the byte offset
  if (SIZE < 1 || SIZE + 2 > WIDTH) begin : g_size_check
    $error("fetch_unit: SIZE must leave room for the byte offset within WIDTH");
  end

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] inflight_pc_q;
  logic             inflight_q;
  logic             squash_q;

  logic [WIDTH-1:0] fifo_instr_q [2];
  logic [WIDTH-1:0] fifo_pc_q    [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;

  logic             out_valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       credit;
  logic [WIDTH-1:0] redirect_target;

  // Handshake, credit check and output muxing
  always_comb begin
    out_valid       = (count_q != 2'd0);
    pop             = out_valid & bus.out_ready;
    // pop implies count_q >= 1, so this never underflows
    credit          = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // held off while reset is asserted so imem_req reads 0 in reset
    issue           = reset & ~bus.redirect_valid & (credit < 3'd2);
    // a redirect flushes the FIFO, so a response landing in that cycle is dropped too
    push            = inflight_q & ~squash_q & ~bus.redirect_valid;
    redirect_target = bus.redirect_pc & ALIGN_MASK;

    bus.out_valid   = out_valid;
    bus.out_instr   = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    bus.out_pc      = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    bus.imem_req    = issue;
    bus.imem_addr   = pc_q;
  end

  // PC, in-flight tracking and squash of stale responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q       <= redirect_target;
      inflight_q <= 1'b0;
      squash_q   <= inflight_q;
    end else begin
      squash_q   <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + WIDTH'(4);
        inflight_pc_q <= pc_q;
      end
    end
  end

  // Two-entry {instr, pc} FIFO; push and pop may coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (bus.redirect_valid) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table drives the
// consumer/redirect/reset inputs and holds hand-computed request/valid
// expectations; expected deliveries go into queues that a negedge
// monitor drains on every handshake.
module tb_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(32)) if0 ();
  fetch_unit_if #(.WIDTH(32)) if1 ();

  fetch_unit #(.WIDTH(32), .SIZE(23), .RESET_PC(32'h0000_0000)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.master)
  );

  fetch_unit #(.WIDTH(32), .SIZE(23), .RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );

  // synchronous-read imem models; garbage when not requested
  always @(posedge clk) begin
    if0.imem_rdata <= if0.imem_req ? (if0.imem_addr ^ PAT) : 32'hDEAD_BEEF;
    if1.imem_rdata <= if1.imem_req ? (if1.imem_addr ^ PAT) : 32'hDEAD_BEEF;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // scoreboard monitor: every accepted instruction must match the queue head
  always @(negedge clk) begin
    if (if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL sb0_extra: got pc %h expected no delivery", if0.out_pc);
      end else begin
        e0 = q0.pop_front();
        check("sb0_pc", if0.out_pc, e0.pc);
        check("sb0_instr", if0.out_instr, e0.instr);
      end
    end
    if (if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_extra: got pc %h expected no delivery", if1.out_pc);
      end else begin
        e1 = q1.pop_front();
        check("sb1_pc", if1.out_pc, e1.pc);
        check("sb1_instr", if1.out_instr, e1.instr);
      end
    end
  end

  typedef struct {
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          rstp;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    bit          pop;
    logic [31:0] ppc;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input bit rdy, input bit redir, input logic [31:0] rpc, input bit rstp,
                     input bit req, input logic [31:0] addr, input bit vld,
                     input bit pop, input logic [31:0] ppc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.rstp = rstp;
    v.req = req; v.addr = addr; v.vld = vld; v.pop = pop; v.ppc = ppc;
    vecs.push_back(v);
  endtask

  logic [31:0] wrap_pc [4];
  vec_t        v;
  exp_t        ex;

  initial begin
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;
    wrap_pc[3] = 32'h0000_0004;

    //   rdy redir rpc        rst req addr       vld pop ppc
    // free run from reset
    row(1, 0, 32'h0,    0, 1, 32'h000,  0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h004,  0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h008,  1, 1, 32'h000);
    row(1, 0, 32'h0,    0, 1, 32'h00C,  1, 1, 32'h004);
    row(1, 0, 32'h0,    0, 1, 32'h010,  1, 1, 32'h008);
    row(1, 0, 32'h0,    0, 1, 32'h014,  1, 1, 32'h00C);
    // redirect together with the pop of pc 0x10
    row(1, 1, 32'h200,  0, 0, 32'h018,  1, 1, 32'h010);
    row(1, 0, 32'h0,    0, 1, 32'h200,  0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h204,  0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h208,  1, 1, 32'h200);
    row(1, 0, 32'h0,    0, 1, 32'h20C,  1, 1, 32'h204);
    row(1, 0, 32'h0,    0, 1, 32'h210,  1, 1, 32'h208);
    // backpressure: count 1 + inflight 1 already uses both credits
    for (int k = 0; k < 6; k++)
      row(0, 0, 32'h0,  0, 0, 32'h214,  1, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h214,  1, 1, 32'h20C);
    row(1, 0, 32'h0,    0, 1, 32'h218,  1, 1, 32'h210);
    row(1, 0, 32'h0,    0, 1, 32'h21C,  1, 1, 32'h214);
    row(1, 0, 32'h0,    0, 1, 32'h220,  1, 1, 32'h218);
    // misaligned redirect with 0x21C buffered and 0x220 in flight
    row(0, 1, 32'h1002, 0, 0, 32'h224,  1, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h1000, 0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h1004, 0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h1008, 1, 1, 32'h1000);
    row(1, 0, 32'h0,    0, 1, 32'h100C, 1, 1, 32'h1004);
    row(1, 0, 32'h0,    0, 1, 32'h1010, 1, 1, 32'h1008);
    // back-to-back redirects, the second wins
    row(1, 1, 32'h3000, 0, 0, 32'h1014, 1, 1, 32'h100C);
    row(1, 1, 32'h4004, 0, 0, 32'h3000, 0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h4004, 0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h4008, 0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h400C, 1, 1, 32'h4004);
    row(1, 0, 32'h0,    0, 1, 32'h4010, 1, 1, 32'h4008);
    row(1, 0, 32'h0,    0, 1, 32'h4014, 1, 1, 32'h400C);
    // half-cycle reset pulse with 0x4010 buffered
    row(1, 0, 32'h0,    1, 1, 32'h000,  0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h004,  0, 0, 32'h0);
    row(1, 0, 32'h0,    0, 1, 32'h008,  1, 1, 32'h000);
    row(1, 0, 32'h0,    0, 1, 32'h00C,  1, 1, 32'h004);
    row(1, 0, 32'h0,    0, 1, 32'h010,  1, 1, 32'h008);

    if0.out_ready = 1'b1; if0.redirect_valid = 1'b0; if0.redirect_pc = '0;
    if1.out_ready = 1'b1; if1.redirect_valid = 1'b0; if1.redirect_pc = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'b0, if0.imem_req}, 32'd0);
    check("rst_addr", if0.imem_addr, 32'h0);
    check("rst_valid", {31'b0, if0.out_valid}, 32'd0);
    check("rst_instr", if0.out_instr, 32'h0);
    check("rst_pc", if0.out_pc, 32'h0);
    check("rst_req1", {31'b0, if1.imem_req}, 32'd0);
    check("rst_addr1", if1.imem_addr, 32'hFFFF_FFF8);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      if0.out_ready      = v.rdy;
      if0.redirect_valid = v.redir;
      if0.redirect_pc    = v.rpc;
      if1.out_ready      = (i < 6);
      if (v.pop) begin
        ex.pc = v.ppc; ex.instr = v.ppc ^ PAT;
        q0.push_back(ex);
      end
      if (i >= 2 && i < 6) begin
        ex.pc = wrap_pc[i-2]; ex.instr = wrap_pc[i-2] ^ PAT;
        q1.push_back(ex);
      end
      reset = 1'b1;
      if (v.rstp) begin
        reset = 1'b0;
        #1;
        check("pulse_valid", {31'b0, if0.out_valid}, 32'd0);
        check("pulse_req", {31'b0, if0.imem_req}, 32'd0);
        check("pulse_addr", if0.imem_addr, 32'h0);
        check("pulse_pc", if0.out_pc, 32'h0);
        check("pulse_instr", if0.out_instr, 32'h0);
        #2;
        reset = 1'b1;
      end
      @(negedge clk);
      check($sformatf("c%0d_req", i), {31'b0, if0.imem_req}, {31'b0, v.req});
      check($sformatf("c%0d_addr", i), if0.imem_addr, v.addr);
      check($sformatf("c%0d_valid", i), {31'b0, if0.out_valid}, {31'b0, v.vld});
      if (i < 4)
        check($sformatf("c%0d_wrap_addr", i), if1.imem_addr, wrap_pc[i]);
    end

    @(posedge clk);
    #1;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sb0_left", q0.size(), 32'd0);
    check("sb1_left", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
